cpu65xx_bus_bridge: RTL

// - Sits directly downstream of the Cpu6502 core, on its address/dataOut/nWrite bus.
// - Paces the core through its enable input and turns each CPU bus cycle into a req/ack memory transaction.
// - Holds the core until the memory side answers, then returns read data on the core's dataIn.
// - Provides a minimum CPU cycle length, a timeout with sticky error flag, and a stall counter.

---
 rtl/cpu65xx_bus_bridge_if.sv | 28 ++
 rtl/cpu65xx_bus_bridge.sv | 115 +++++++++++
 2 files changed

// File: rtl/cpu65xx_bus_bridge_if.sv
// Bus bundle between a 6502-style core, the bus bridge and the memory side.
// The master view belongs to the bridge. The slave view is the core plus memory environment.
interface cpu65xx_bus_bridge_if;
  logic        cpuEnable;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataOut;
  logic        cpuNWrite;
  logic [7:0]  cpuDataIn;
  logic        memReq;
  logic        memWrite;
  logic [15:0] memAddress;
  logic [7:0]  memWData;
  logic [7:0]  memRData;
  logic        memAck;
  logic        busError;
  logic        busErrorClear;
  logic [15:0] stallCount;

  modport master (
    output cpuEnable, cpuDataIn, memReq, memWrite, memAddress, memWData, busError, stallCount,
    input  cpuAddress, cpuDataOut, cpuNWrite, memRData, memAck, busErrorClear
  );

  modport slave (
    input  cpuEnable, cpuDataIn, memReq, memWrite, memAddress, memWData, busError, stallCount,
    output cpuAddress, cpuDataOut, cpuNWrite, memRData, memAck, busErrorClear
  );
endinterface

// File: rtl/cpu65xx_bus_bridge.sv
// Paces a 6502-style core and turns each CPU bus cycle into a req/ack memory transaction.
// It also enforces a minimum cycle length, a timeout with a sticky error flag, and a stall counter.
module cpu65xx_bus_bridge #(
  parameter int CYCLE_DIV = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clock,
  input  logic                        nReset,
  cpu65xx_bus_bridge_if.master        bus
);

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_STEP} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CYCLE_DIV - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_e      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [7:0]  to_cnt, to_nxt;
  logic        en_nxt, req_nxt, wr_nxt, err_nxt;
  logic [15:0] addr_nxt, stall_nxt;
  logic [7:0]  wd_nxt, din_nxt;
  logic        ack, expired, div_done;

  // An ack only counts while a request is outstanding.
  assign ack      = bus.memReq & bus.memAck;
  assign expired  = (to_cnt == TO_LAST);
  assign div_done = (div_cnt == DIV_LAST);

  // NOTE: memReq and the other outputs share the async reset, so an abandoned request drops at once.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state          <= ST_ISSUE;
      div_cnt        <= '0;
      to_cnt         <= '0;
      bus.cpuEnable  <= 1'b0;
      bus.memReq     <= 1'b0;
      bus.memWrite   <= 1'b0;
      bus.memAddress <= '0;
      bus.memWData   <= '0;
      bus.cpuDataIn  <= '0;
      bus.busError   <= 1'b0;
      bus.stallCount <= '0;
    end else begin
      state          <= state_nxt;
      div_cnt        <= div_nxt;
      to_cnt         <= to_nxt;
      bus.cpuEnable  <= en_nxt;
      bus.memReq     <= req_nxt;
      bus.memWrite   <= wr_nxt;
      bus.memAddress <= addr_nxt;
      bus.memWData   <= wd_nxt;
      bus.cpuDataIn  <= din_nxt;
      bus.busError   <= err_nxt;
      bus.stallCount <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ack || expired) state_nxt = ST_HOLD;
      ST_HOLD:  if (div_done) state_nxt = ST_STEP;
      ST_STEP:  state_nxt = ST_ISSUE;
      default:  state_nxt = ST_ISSUE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    en_nxt    = 1'b0;
    req_nxt   = bus.memReq;
    wr_nxt    = bus.memWrite;
    addr_nxt  = bus.memAddress;
    wd_nxt    = bus.memWData;
    din_nxt   = bus.cpuDataIn;
    err_nxt   = bus.busError & ~bus.busErrorClear;
    stall_nxt = bus.busErrorClear ? 16'd0 : bus.stallCount;
    to_nxt    = to_cnt;
    div_nxt   = div_done ? div_cnt : div_cnt + 8'd1;
    case (state)
      ST_ISSUE: begin
        addr_nxt = bus.cpuAddress;
        wd_nxt   = bus.cpuDataOut;
        wr_nxt   = ~bus.cpuNWrite;
        req_nxt  = 1'b1;
        to_nxt   = '0;
      end
      ST_WAIT: begin
        if (ack) begin
          req_nxt = 1'b0;
          if (!bus.memWrite) din_nxt = bus.memRData;
        end else if (expired) begin
          req_nxt = 1'b0;
          err_nxt = 1'b1;
          if (!bus.memWrite) din_nxt = 8'hFF;
        end else begin
          to_nxt = to_cnt + 8'd1;
          if (!bus.busErrorClear && bus.stallCount != 16'hFFFF)
            stall_nxt = bus.stallCount + 16'd1;
        end
      end
      ST_HOLD: begin
        // Clearing on entry makes STEP the zero count, so ISSUE through STEP spans CYCLE_DIV clocks.
        if (div_done) begin
          en_nxt  = 1'b1;
          div_nxt = '0;
        end
      end
      default: ;
    endcase
  end

endmodule
